// File: rtl/and_gate_response_checker_if.sv
// Sample/response bus between the AND gate test harness and its response checker.
// The harness drives samples and control as master; the checker reports results as slave.
interface and_gate_response_checker_if #(
  parameter int ERR_W = 8
);
  logic             start;
  logic             vec_valid;
  logic [3:0]       vec_in;
  logic [2:0]       resp_in;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_cnt;
  logic [15:0]      cover_mask;
  logic [3:0]       first_err_vec;
  logic [2:0]       first_err_resp;

  modport master (
    output start, vec_valid, vec_in, resp_in,
    input  busy, done, pass, err_cnt, cover_mask, first_err_vec, first_err_resp
  );

  modport slave (
    input  start, vec_valid, vec_in, resp_in,
    output busy, done, pass, err_cnt, cover_mask, first_err_vec, first_err_resp
  );
endinterface

// File: rtl/and_gate_response_checker.sv
// Checks a four-input AND gate's {g,f,e} response against a golden model,
// tracks coverage of all 16 input vectors and reports pass/fail on completion or timeout.
module and_gate_response_checker #(
  parameter int ERR_W   = 8,
  parameter int TIMEOUT = 1000
) (
  input logic                  clk,
  input logic                  rst,
  and_gate_response_checker_if.slave bus
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [TMO_W-1:0] tmo;
  logic [ERR_W-1:0] err_q, err_next;
  logic [15:0]      cover_q, cover_next;
  logic [3:0]       first_vec_q;
  logic [2:0]       first_resp_q;
  logic             pass_q;
  logic [2:0]       expected;
  logic             sample;
  logic             mismatch;
  logic             finish;

  // Golden response: bit0 = a&b, bit1 = c&d, bit2 = a&b&c&d.
  always_comb begin
    expected   = {&bus.vec_in, &bus.vec_in[1:0], &bus.vec_in[3:2]};
    sample     = (state == RUN) && bus.vec_valid;
    mismatch   = sample && (bus.resp_in != expected);
    cover_next = cover_q;
    if (sample) begin
      cover_next = cover_q | (16'b1 << bus.vec_in);
    end
    err_next = err_q;
    if (mismatch && (err_q != {ERR_W{1'b1}})) begin
      err_next = err_q + ERR_W'(1);
    end
    finish = (state == RUN) && ((cover_q == 16'hFFFF) || (tmo == TMO_LAST));
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (finish)    state_next = DONE;
      DONE:    if (bus.start) state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      tmo          <= '0;
      err_q        <= '0;
      cover_q      <= '0;
      first_vec_q  <= '0;
      first_resp_q <= '0;
      pass_q       <= 1'b0;
    end else begin
      state <= state_next;
      if ((state != RUN) && bus.start) begin
        tmo          <= '0;
        err_q        <= '0;
        cover_q      <= '0;
        first_vec_q  <= '0;
        first_resp_q <= '0;
        pass_q       <= 1'b0;
      end else if (state == RUN) begin
        cover_q <= cover_next;
        err_q   <= err_next;
        if (mismatch && (err_q == '0)) begin
          first_vec_q  <= bus.vec_in;
          first_resp_q <= bus.resp_in;
        end
        // A sample landing on the completion edge still counts toward pass.
        if (finish) begin
          pass_q <= (err_next == '0) && (cover_next == 16'hFFFF);
        end else begin
          tmo <= tmo + TMO_W'(1);
        end
      end
    end
  end

  assign bus.busy           = (state == RUN);
  assign bus.done           = (state == DONE);
  assign bus.pass           = pass_q;
  assign bus.err_cnt        = err_q;
  assign bus.cover_mask     = cover_q;
  assign bus.first_err_vec  = first_vec_q;
  assign bus.first_err_resp = first_resp_q;

endmodule

// File: tb/tb_and_gate_response_checker.sv
// Drives two checkers (8-bit and 2-bit error counters) with identical directed and
// random samples, comparing every cycle against a behavioural model of the checker.
module tb_and_gate_response_checker;

  localparam int TMO = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_s = 1'b0;
  logic       valid_s = 1'b0;
  logic [3:0] vec_s = '0;
  logic [2:0] resp_s = '0;

  int compared = 0;
  int mismatched = 0;

  and_gate_response_checker_if #(.ERR_W(8)) bus0 ();
  and_gate_response_checker_if #(.ERR_W(2)) bus1 ();

  assign bus0.start = start_s;  assign bus1.start = start_s;
  assign bus0.vec_valid = valid_s; assign bus1.vec_valid = valid_s;
  assign bus0.vec_in = vec_s;   assign bus1.vec_in = vec_s;
  assign bus0.resp_in = resp_s; assign bus1.resp_in = resp_s;

  and_gate_response_checker #(.ERR_W(8), .TIMEOUT(TMO)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  and_gate_response_checker #(.ERR_W(2), .TIMEOUT(TMO)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  always #5 clk = ~clk;

  // Model state: mode 0 idle, 1 checking, 2 finished.
  int       m_mode[2];
  int       m_cyc[2];
  bit [15:0] m_cov[2];
  int       m_err[2];
  int       m_fv[2];
  int       m_fr[2];
  int       m_pass[2];
  int       m_max[2] = '{255, 3};
  bit       was_full;
  bit       expired;

  function automatic int golden(int v);
    return ((v == 15) ? 4 : 0) + ((v % 4 == 3) ? 2 : 0) + ((v / 4 == 3) ? 1 : 0);
  endfunction

  task automatic checkOutput(string name, int act, int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(bit st, bit vv, int v, int r);
    start_s = st;
    valid_s = vv;
    vec_s   = 4'(v);
    resp_s  = 3'(r);
    @(negedge clk);
  endtask

  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_mode[k] = 0; m_cyc[k] = 0; m_cov[k] = '0;
        m_err[k] = 0; m_fv[k] = 0; m_fr[k] = 0; m_pass[k] = 0;
      end else if (m_mode[k] == 1) begin
        was_full = (m_cov[k] == 16'hFFFF);
        expired  = (m_cyc[k] == TMO - 1);
        if (valid_s) begin
          m_cov[k][vec_s] = 1'b1;
          if (int'(resp_s) != golden(int'(vec_s))) begin
            if (m_err[k] == 0) begin
              m_fv[k] = int'(vec_s);
              m_fr[k] = int'(resp_s);
            end
            if (m_err[k] < m_max[k]) m_err[k]++;
          end
        end
        if (was_full || expired) begin
          m_mode[k] = 2;
          m_pass[k] = (m_err[k] == 0 && m_cov[k] == 16'hFFFF) ? 1 : 0;
        end else begin
          m_cyc[k]++;
        end
      end else if (start_s) begin
        m_mode[k] = 1; m_cyc[k] = 0; m_cov[k] = '0;
        m_err[k] = 0; m_fv[k] = 0; m_fr[k] = 0; m_pass[k] = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("busy0", int'(bus0.busy), int'(m_mode[0] == 1));
      checkOutput("done0", int'(bus0.done), int'(m_mode[0] == 2));
      checkOutput("pass0", int'(bus0.pass), m_pass[0]);
      checkOutput("err0", int'(bus0.err_cnt), m_err[0]);
      checkOutput("cover0", int'(bus0.cover_mask), int'(m_cov[0]));
      checkOutput("fvec0", int'(bus0.first_err_vec), m_fv[0]);
      checkOutput("fresp0", int'(bus0.first_err_resp), m_fr[0]);
      checkOutput("busy1", int'(bus1.busy), int'(m_mode[1] == 1));
      checkOutput("done1", int'(bus1.done), int'(m_mode[1] == 2));
      checkOutput("pass1", int'(bus1.pass), m_pass[1]);
      checkOutput("err1", int'(bus1.err_cnt), m_err[1]);
      checkOutput("cover1", int'(bus1.cover_mask), int'(m_cov[1]));
      checkOutput("fvec1", int'(bus1.first_err_vec), m_fv[1]);
      checkOutput("fresp1", int'(bus1.first_err_resp), m_fr[1]);
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkAllZero(string tag);
    checkOutput({tag, "_busy"}, int'(bus0.busy), 0);
    checkOutput({tag, "_done"}, int'(bus0.done), 0);
    checkOutput({tag, "_pass"}, int'(bus0.pass), 0);
    checkOutput({tag, "_err"}, int'(bus0.err_cnt), 0);
    checkOutput({tag, "_cover"}, int'(bus0.cover_mask), 0);
    checkOutput({tag, "_fvec"}, int'(bus0.first_err_vec), 0);
    checkOutput({tag, "_fresp"}, int'(bus0.first_err_resp), 0);
    checkOutput({tag, "_err1"}, int'(bus1.err_cnt), 0);
    checkOutput({tag, "_busy1"}, int'(bus1.busy), 0);
  endtask

  initial begin
    int r;
    repeat (2) @(negedge clk);
    checkAllZero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Samples in IDLE are ignored.
    applyStimulus(1'b0, 1'b1, 3, 7);
    checkOutput("idle_cover", int'(bus0.cover_mask), 0);
    checkOutput("idle_err", int'(bus0.err_cnt), 0);

    // Golden sweep.
    applyStimulus(1'b1, 1'b0, 0, 0);
    checkOutput("sweep_busy", int'(bus0.busy), 1);
    for (int i = 0; i < 16; i++) applyStimulus(1'b0, 1'b1, i, golden(i));
    checkOutput("sweep_cover", int'(bus0.cover_mask), 16'hFFFF);
    checkOutput("sweep_notdone", int'(bus0.done), 0);
    applyStimulus(1'b0, 1'b0, 0, 0);
    checkOutput("sweep_done", int'(bus0.done), 1);
    checkOutput("sweep_pass", int'(bus0.pass), 1);
    checkOutput("sweep_err", int'(bus0.err_cnt), 0);

    // Samples in DONE are ignored.
    applyStimulus(1'b0, 1'b1, 0, 7);
    checkOutput("doneval_err", int'(bus0.err_cnt), 0);
    checkOutput("doneval_pass", int'(bus0.pass), 1);

    // Restart from DONE, then a sweep with two faults.
    applyStimulus(1'b1, 1'b0, 0, 0);
    checkOutput("restart_busy", int'(bus0.busy), 1);
    checkOutput("restart_cover", int'(bus0.cover_mask), 0);
    checkOutput("restart_pass", int'(bus0.pass), 0);
    for (int i = 0; i < 16; i++)
      applyStimulus(1'b0, 1'b1, i, (i == 12) ? 3 : (i == 15) ? 0 : golden(i));
    applyStimulus(1'b0, 1'b0, 0, 0);
    checkOutput("fault_err", int'(bus0.err_cnt), 2);
    checkOutput("fault_fvec", int'(bus0.first_err_vec), 12);
    checkOutput("fault_fresp", int'(bus0.first_err_resp), 3);
    checkOutput("fault_pass", int'(bus0.pass), 0);
    checkOutput("fault_done", int'(bus0.done), 1);

    // Timeout with half coverage; a start pulse mid-run must not restart.
    applyStimulus(1'b1, 1'b0, 0, 0);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, i, golden(i));
    applyStimulus(1'b1, 1'b0, 0, 0);
    checkOutput("busystart_cover", int'(bus0.cover_mask), 16'h00FF);
    checkOutput("busystart_busy", int'(bus0.busy), 1);
    repeat (30) applyStimulus(1'b0, 1'b0, 0, 0);
    checkOutput("tmo_notdone", int'(bus0.done), 0);
    applyStimulus(1'b0, 1'b0, 0, 0);
    checkOutput("tmo_done", int'(bus0.done), 1);
    checkOutput("tmo_cover", int'(bus0.cover_mask), 16'h00FF);
    checkOutput("tmo_pass", int'(bus0.pass), 0);

    // Saturation of the 2-bit counter.
    applyStimulus(1'b1, 1'b0, 0, 0);
    repeat (5) applyStimulus(1'b0, 1'b1, 0, 7);
    checkOutput("sat_err1", int'(bus1.err_cnt), 3);
    checkOutput("sat_err0", int'(bus0.err_cnt), 5);
    applyStimulus(1'b0, 1'b1, 0, 7);
    checkOutput("sat_hold1", int'(bus1.err_cnt), 3);
    checkOutput("sat_fresp", int'(bus1.first_err_resp), 7);

    // Reset in the middle of a run.
    applyStimulus(1'b0, 1'b1, 1, 0);
    rst = 1'b1;
    #1;
    checkAllZero("midreset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Random sessions with occasional stray starts.
    for (int s = 0; s < 8; s++) begin
      applyStimulus(1'b1, 1'b0, 0, 0);
      for (int c = 0; c < 60; c++) begin
        r = $urandom_range(0, 15);
        applyStimulus(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0), r,
                      ($urandom_range(0, 9) < 8) ? golden(r) : $urandom_range(0, 7));
      end
    end
    applyStimulus(1'b0, 1'b0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
